// File: rtl/parity_share_sched_pkg.sv
// Shared definitions for the parity sharing scheduler: FSM encoding,
// default geometry and the sizing helpers used by the top and the arbiter.
package parity_share_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N     = 4;
    localparam int DEF_W     = 24;
    localparam int DEF_LANES = 2;

    // Width needed to index 'value' items; never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Number of fold cycles for a word: each cycle eats 3*LANES bits.
    function automatic int num_chunks(input int w, input int lanes);
        return w / (3 * lanes);
    endfunction

endpackage

// File: rtl/parity_share_sched_rr_arb_n.sv
// Combinational round-robin select: first valid requester at or after the
// pointer, wrapping modulo N.
module rr_arb_n
    import parity_share_sched_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_winner,
    output logic          o_any
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (!w_found && i_valid[w_idx]) begin
                w_found  = 1'b1;
                o_winner = IW'(w_idx);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/parity_share_sched.sv
// Round-robin scheduler sharing one multi-cycle XOR3 parity fold among N
// requesters; returns the parity tagged with the served requester's ID.
module parity_share_sched
    import parity_share_sched_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int W     = DEF_W,
    parameter int LANES = DEF_LANES
) (
    input  logic                CLK,
    input  logic                RSTB,
    input  logic [N-1:0]        REQ_VALID,
    input  logic [N*W-1:0]      REQ_DATA,
    output logic [N-1:0]        REQ_READY,
    output logic                RSP_VALID,
    output logic                RSP_PARITY,
    output logic [clog2(N)-1:0] RSP_ID,
    input  logic                RSP_READY,
    output logic                BUSY
);

    localparam int IW  = clog2(N);
    localparam int CHW = 3 * LANES;
    localparam int C   = num_chunks(W, LANES);
    localparam int CW  = clog2(C);

    if (W % (3 * LANES) != 0) begin : g_bad_width
        $error("parity_share_sched: W must be a multiple of 3*LANES");
    end
    if (N < 2 || N > 16) begin : g_bad_n
        $error("parity_share_sched: N must be in 2..16");
    end

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [CW-1:0] r_cnt;
    logic          r_acc;
    logic [W-1:0]  r_data;
    logic [IW-1:0] r_id;
    logic          r_rsp_valid;
    logic          r_busy;

    logic [IW-1:0]    w_winner;
    logic             w_any;
    logic [W-1:0]     w_req_word;
    logic [CHW-1:0]   w_chunk;
    logic [LANES-1:0] w_lane;
    logic             w_fold;

    rr_arb_n #(.N(N), .IW(IW)) u_arb (
        .i_valid  (REQ_VALID),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    assign w_req_word = REQ_DATA[int'(w_winner)*W +: W];

    // Ready is suppressed while reset is asserted so all outputs read zero.
    always_comb begin
        REQ_READY = '0;
        if (RSTB && r_state == ST_IDLE && w_any) REQ_READY[w_winner] = 1'b1;
    end

    assign w_chunk = r_data[int'(r_cnt)*CHW +: CHW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane[l] = w_chunk[3*l] ^ w_chunk[3*l+1] ^ w_chunk[3*l+2];
    end
    assign w_fold = ^w_lane;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_cnt       <= '0;
            r_acc       <= 1'b0;
            r_data      <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_data  <= w_req_word;
                        r_id    <= w_winner;
                        r_acc   <= 1'b0;
                        r_cnt   <= '0;
                        r_ptr   <= (w_winner == IW'(N-1)) ? '0 : w_winner + IW'(1);
                        r_busy  <= 1'b1;
                        r_state <= ST_FOLD;
                    end
                end
                ST_FOLD: begin
                    r_acc <= r_acc ^ w_fold;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(C-1)) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign RSP_VALID  = r_rsp_valid;
    assign RSP_PARITY = r_acc;
    assign RSP_ID     = r_id;
    assign BUSY       = r_busy;

endmodule

// File: tb/tb_parity_share_sched.sv
// Directed bench for parity_share_sched at default geometry (N=4, W=24, LANES=2).
module tb_parity_share_sched;

    localparam int N = 4;
    localparam int W = 24;

    logic           CLK = 1'b0;
    logic           RSTB;
    logic [N-1:0]   REQ_VALID;
    logic [N*W-1:0] REQ_DATA;
    logic [N-1:0]   REQ_READY;
    logic           RSP_VALID;
    logic           RSP_PARITY;
    logic [1:0]     RSP_ID;
    logic           RSP_READY;
    logic           BUSY;

    int n_run  = 0;
    int n_fail = 0;

    parity_share_sched #(.N(N), .W(W), .LANES(2)) dut (
        .CLK        (CLK),
        .RSTB       (RSTB),
        .REQ_VALID  (REQ_VALID),
        .REQ_DATA   (REQ_DATA),
        .REQ_READY  (REQ_READY),
        .RSP_VALID  (RSP_VALID),
        .RSP_PARITY (RSP_PARITY),
        .RSP_ID     (RSP_ID),
        .RSP_READY  (RSP_READY),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_word(input int req, input logic [W-1:0] word);
        REQ_DATA[req*W +: W] = word;
    endtask

    task automatic pulse_reset();
        RSTB = 1'b0;
        step();
        step();
        RSTB = 1'b1;
    endtask

    // One full transaction with RSP_READY high; reports grant, latency from
    // the accept cycle to the first RSP_VALID cycle, and the response fields.
    task automatic do_txn(input logic [N-1:0] valid, output logic [N-1:0] grant,
                          output int lat, output logic par, output logic [1:0] id);
        grant = '0;
        lat   = -1;
        par   = 1'bx;
        id    = 2'bxx;
        REQ_VALID = valid;
        RSP_READY = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge CLK);
            if (REQ_READY != '0) begin
                grant = REQ_READY;
                break;
            end
            step();
        end
        step();
        REQ_VALID = '0;
        if (grant != '0) begin
            for (int l = 1; l <= 12; l++) begin
                @(negedge CLK);
                if (RSP_VALID) begin
                    lat = l;
                    par = RSP_PARITY;
                    id  = RSP_ID;
                    break;
                end
                step();
            end
        end
        step();
    endtask

    task automatic test_reset();
        RSTB      = 1'b0;
        REQ_VALID = 4'hF;
        REQ_DATA  = '0;
        RSP_READY = 1'b0;
        step();
        step();
        @(negedge CLK);
        n_run++; if (REQ_READY !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=0000", REQ_READY); end
        n_run++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", RSP_VALID); end
        n_run++; if (RSP_PARITY !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_parity got=%b exp=0", RSP_PARITY); end
        n_run++; if (RSP_ID !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", RSP_ID); end
        n_run++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        REQ_VALID = '0;
        step();
        RSTB = 1'b1;
        @(negedge CLK);
        n_run++; if (BUSY !== 1'b0 || REQ_READY !== 4'b0000) begin n_fail++; $display("FAIL idle_after_reset busy=%b ready=%b exp busy=0 ready=0000", BUSY, REQ_READY); end
        step();
    endtask

    task automatic test_single();
        logic [N-1:0] g; int lat; logic p; logic [1:0] id;
        set_word(2, 24'h000001);
        do_txn(4'b0100, g, lat, p, id);
        n_run++; if (g !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", g); end
        n_run++; if (lat !== 5) begin n_fail++; $display("FAIL single_latency got=%0d exp=5", lat); end
        n_run++; if (p !== 1'b1) begin n_fail++; $display("FAIL single_parity got=%b exp=1", p); end
        n_run++; if (id !== 2'd2) begin n_fail++; $display("FAIL single_id got=%0d exp=2", id); end
        @(negedge CLK);
        n_run++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin n_fail++; $display("FAIL single_back_idle rsp_valid=%b busy=%b exp 0 0", RSP_VALID, BUSY); end
        step();
    endtask

    task automatic test_patterns();
        logic [W-1:0] words [4] = '{24'hFFFFFF, 24'h800007, 24'h000007, 24'hA5A5A5};
        logic         exp_p [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [N-1:0] g; int lat; logic p; logic [1:0] id;
        for (int i = 0; i < 4; i++) begin
            set_word(0, words[i]);
            do_txn(4'b0001, g, lat, p, id);
            n_run++; if (p !== exp_p[i] || id !== 2'd0 || lat !== 5) begin
                n_fail++;
                $display("FAIL pattern_%h parity=%b id=%0d lat=%0d exp parity=%b id=0 lat=5", words[i], p, id, lat, exp_p[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 1, 2, 3, 0, 1};
        int got;
        int last;
        int idx;
        REQ_VALID = 4'hF;
        RSP_READY = 1'b1;
        pulse_reset();
        got  = 0;
        last = -100;
        for (int c = 0; c < 36; c++) begin
            @(negedge CLK);
            if (REQ_READY != '0) begin
                n_run++; if (!$onehot(REQ_READY)) begin n_fail++; $display("FAIL rr_onehot cycle=%0d got=%b exp one-hot", c, REQ_READY); end
                idx = -1;
                for (int b = 0; b < N; b++) if (REQ_READY[b]) idx = b;
                if (got < 6) begin
                    n_run++; if (idx != exp_order[got]) begin n_fail++; $display("FAIL rr_order grant#%0d got=%0d exp=%0d", got, idx, exp_order[got]); end
                end
                if (got > 0) begin
                    n_run++; if (c - last != 6) begin n_fail++; $display("FAIL rr_spacing grant#%0d got=%0d exp=6", got, c - last); end
                end
                got++;
                last = c;
            end
            step();
        end
        n_run++; if (got != 6) begin n_fail++; $display("FAIL rr_count got=%0d exp=6", got); end
        REQ_VALID = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge CLK);
            if (!BUSY && !RSP_VALID) break;
            step();
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] g;
        int lat;
        pulse_reset();
        set_word(0, 24'h000007);
        set_word(1, 24'h000003);
        REQ_VALID = 4'b0001;
        RSP_READY = 1'b0;
        g = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge CLK);
            if (REQ_READY != '0) begin g = REQ_READY; break; end
            step();
        end
        n_run++; if (g !== 4'b0001) begin n_fail++; $display("FAIL bp_grant got=%b exp=0001", g); end
        step();
        REQ_VALID = '0;
        lat = -1;
        for (int l = 1; l <= 12; l++) begin
            @(negedge CLK);
            if (RSP_VALID) begin lat = l; break; end
            step();
        end
        n_run++; if (lat != 5) begin n_fail++; $display("FAIL bp_latency got=%0d exp=5", lat); end
        step();
        REQ_VALID = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            n_run++;
            if (RSP_VALID !== 1'b1 || RSP_PARITY !== 1'b1 || RSP_ID !== 2'd0 || REQ_READY !== 4'b0000 || BUSY !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cycle=%0d valid=%b parity=%b id=%0d ready=%b busy=%b exp 1 1 0 0000 1",
                         i, RSP_VALID, RSP_PARITY, RSP_ID, REQ_READY, BUSY);
            end
            step();
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        n_run++; if (RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid got=%b exp=1", RSP_VALID); end
        step();
        @(negedge CLK);
        n_run++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b0 || REQ_READY !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_idle valid=%b busy=%b ready=%b exp 0 0 0010", RSP_VALID, BUSY, REQ_READY);
        end
        step();
        REQ_VALID = '0;
        lat = -1;
        for (int l = 1; l <= 12; l++) begin
            @(negedge CLK);
            if (RSP_VALID) begin
                lat = l;
                n_run++; if (RSP_ID !== 2'd1 || RSP_PARITY !== 1'b0) begin n_fail++; $display("FAIL bp_next_rsp id=%0d parity=%b exp id=1 parity=0", RSP_ID, RSP_PARITY); end
                break;
            end
            step();
        end
        n_run++; if (lat != 5) begin n_fail++; $display("FAIL bp_next_latency got=%0d exp=5", lat); end
        step();
    endtask

    task automatic test_reset_mid_fold();
        logic [N-1:0] g; int lat; logic p; logic [1:0] id;
        int seen_rsp;
        RSP_READY = 1'b1;
        pulse_reset();
        set_word(2, 24'h000001);
        set_word(1, 24'h0000F1);
        REQ_VALID = 4'b0100;
        g = '0;
        for (int t = 0; t < 12; t++) begin
            @(negedge CLK);
            if (REQ_READY != '0) begin g = REQ_READY; break; end
            step();
        end
        n_run++; if (g !== 4'b0100) begin n_fail++; $display("FAIL mid_grant got=%b exp=0100", g); end
        step();
        REQ_VALID = '0;
        step();
        #2;
        RSTB = 1'b0;
        REQ_VALID = 4'b1010;
        #1;
        n_run++; if (REQ_READY !== 4'b0000 || RSP_VALID !== 1'b0 || RSP_PARITY !== 1'b0 || RSP_ID !== 2'd0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_reset ready=%b valid=%b parity=%b id=%0d busy=%b exp all zero",
                     REQ_READY, RSP_VALID, RSP_PARITY, RSP_ID, BUSY);
        end
        seen_rsp = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) seen_rsp++;
            step();
        end
        n_run++; if (seen_rsp != 0) begin n_fail++; $display("FAIL mid_no_response got=%0d active cycles exp=0", seen_rsp); end
        RSTB = 1'b1;
        do_txn(4'b1010, g, lat, p, id);
        n_run++; if (g !== 4'b0010) begin n_fail++; $display("FAIL mid_after_grant got=%b exp=0010", g); end
        n_run++; if (id !== 2'd1 || p !== 1'b1 || lat !== 5) begin n_fail++; $display("FAIL mid_after_rsp id=%0d parity=%b lat=%0d exp id=1 parity=1 lat=5", id, p, lat); end
    endtask

    task automatic test_pointer_wrap();
        logic [N-1:0] g; int lat; logic p; logic [1:0] id;
        pulse_reset();
        set_word(3, 24'h000003);
        set_word(0, 24'h000001);
        do_txn(4'b1000, g, lat, p, id);
        n_run++; if (g !== 4'b1000 || id !== 2'd3 || p !== 1'b0) begin n_fail++; $display("FAIL wrap_first grant=%b id=%0d parity=%b exp 1000 3 0", g, id, p); end
        do_txn(4'b1001, g, lat, p, id);
        n_run++; if (g !== 4'b0001 || id !== 2'd0 || p !== 1'b1) begin n_fail++; $display("FAIL wrap_second grant=%b id=%0d parity=%b exp 0001 0 1", g, id, p); end
        do_txn(4'b1001, g, lat, p, id);
        n_run++; if (g !== 4'b1000 || id !== 2'd3) begin n_fail++; $display("FAIL wrap_third grant=%b id=%0d exp 1000 3", g, id); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_patterns();
        test_round_robin();
        test_backpressure();
        test_reset_mid_fold();
        test_pointer_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
